cdb_result_queue: RTL
=====================

CDB_RESULT_QUEUE -- requirements
Module: cdb_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, result-queue entries; power of two, at least 2.
REQ-002 Parameter PD_W, default 6, physical register index width.
REQ-003 Parameter ROB_W, default 5, ROB index width.
REQ-004 Parameter RVFI_W, default 256, opaque RVFI payload width.
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port flush, input, 1, synchronous squash of all queued results.
REQ-008 Port in_valid, input, 1, the execution unit presents a result.
REQ-009 Port in_ready, output, 1, the queue can accept a result this cycle.
REQ-010 Port in_rd, input, 5, architectural destination.
REQ-011 Port in_pd, input, PD_W, physical destination.
REQ-012 Port in_data, input, 32, result value.
REQ-013 Port in_rob_idx, input, ROB_W, ROB slot.
REQ-014 Port in_rvfi, input, RVFI_W, RVFI payload.
REQ-015 Port out_ready_commit, output, 1, the head entry is valid and is requesting the CDB.
REQ-016 Ports out_rd/out_pd/out_data/out_rob_idx/out_rvfi, output, widths as the in_* ports, head-entry payload.
REQ-017 Port cdb_grant, input, 1, the CDB arbiter has selected this unit this cycle (combinational from out_ready_commit).
REQ-018 Port count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-019 The queue SHALL be a circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-020 in_ready SHALL equal (count != DEPTH); it is combinational from state only, with no dependence on cdb_grant.
REQ-021 A push SHALL occur when in_valid && in_ready && !flush, writing the payload at the write pointer.
REQ-022 A pop SHALL occur when cdb_grant && out_ready_commit && !flush, advancing the read pointer.
REQ-023 out_ready_commit SHALL equal (count != 0); the out_* payload SHALL equal the head entry when count != 0 and SHALL be all-zero when count == 0.
REQ-024 Latency SHALL be exactly 1 cycle from push to visibility at the head of an empty queue; there is no same-cycle bypass.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-026 cdb_grant while count == 0 SHALL be ignored with no state change.
REQ-027 in_valid while full SHALL be ignored; the unit holds the result until in_ready is high.
REQ-028 Results SHALL leave in push order; a payload SHALL never be duplicated or dropped except by flush or rst.
REQ-029 flush SHALL set count and both pointers to 0 in the next cycle, overriding push and pop in the same cycle.
REQ-030 The next-state count SHALL equal count + push - pop and SHALL never exceed DEPTH or underflow.

Reset
REQ-031 On rst high at a clock edge, count, rd_ptr and wr_ptr SHALL become 0; rst has priority over flush, push and pop.
REQ-032 After reset, in_ready=1, out_ready_commit=0 and every out_* field = 0.
REQ-033 Entry storage SHALL NOT need to be reset.
REQ-034 Reset asserted mid-operation SHALL discard all entries, including any push or pop in the same cycle.

Verification
REQ-035 Empty-push check: push data=0x11, rob_idx=3 with grant=0. Next cycle out_ready_commit=1, out_data=0x11, count=1.
REQ-036 Fill and order check: push 0xA0..0xA3 on 4 consecutive cycles. Then count=4 and in_ready=0; a 5th push of 0xA4 is ignored. Granting 4 cycles yields 0xA0, 0xA1, 0xA2, 0xA3 in order, then count=0.
REQ-037 Simultaneous push/pop check: with count=2 (0xB0, 0xB1), push 0xB2 with grant=1. Next cycle count=2 and the head is 0xB1. Continue for 2*DEPTH cycles to exercise pointer wrap with no loss.
REQ-038 Spurious grant check: with count=0, assert grant=1 for 3 cycles. Count stays 0, pointers are unchanged, and outputs stay 0.
REQ-039 Flush check: with count=3, assert flush together with push 0xC0 and grant=1. Next cycle count=0 and out_ready_commit=0; 0xC0 is never presented.
REQ-040 Reset check: with count=2, assert rst together with flush=0, push and grant. Next cycle count=0, in_ready=1 and all out_* fields = 0.

Source files
------------

// File: rtl/cdb_result_queue.sv
// Result queue between an execution unit and the common data bus: a circular FIFO
// whose head requests the CDB and is popped when the arbiter grants it.
module cdb_result_queue #(
    parameter int DEPTH  = 4,
    parameter int PD_W   = 6,
    parameter int ROB_W  = 5,
    parameter int RVFI_W = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_rd,
    input  logic [PD_W-1:0]            in_pd,
    input  logic [31:0]                in_data,
    input  logic [ROB_W-1:0]           in_rob_idx,
    input  logic [RVFI_W-1:0]          in_rvfi,
    output logic                       out_ready_commit,
    output logic [4:0]                 out_rd,
    output logic [PD_W-1:0]            out_pd,
    output logic [31:0]                out_data,
    output logic [ROB_W-1:0]           out_rob_idx,
    output logic [RVFI_W-1:0]          out_rvfi,
    input  logic                       cdb_grant,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]        rd_mem_q   [DEPTH];
    logic [PD_W-1:0]   pd_mem_q   [DEPTH];
    logic [31:0]       data_mem_q [DEPTH];
    logic [ROB_W-1:0]  rob_mem_q  [DEPTH];
    logic [RVFI_W-1:0] rvfi_mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, not_empty;

    assign not_empty        = (count_q != '0);
    assign in_ready         = (count_q != CW'(DEPTH));
    assign out_ready_commit = not_empty;
    assign count            = count_q;

    // flush squashes both sides, so a flushed push never lands in storage
    assign push = in_valid && in_ready && !flush;
    assign pop  = cdb_grant && not_empty && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; a write during rst is harmless since the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= in_rd;
            pd_mem_q[wr_ptr_q]   <= in_pd;
            data_mem_q[wr_ptr_q] <= in_data;
            rob_mem_q[wr_ptr_q]  <= in_rob_idx;
            rvfi_mem_q[wr_ptr_q] <= in_rvfi;
        end
    end

    always_comb begin
        out_rd      = '0;
        out_pd      = '0;
        out_data    = '0;
        out_rob_idx = '0;
        out_rvfi    = '0;
        if (not_empty) begin
            out_rd      = rd_mem_q[rd_ptr_q];
            out_pd      = pd_mem_q[rd_ptr_q];
            out_data    = data_mem_q[rd_ptr_q];
            out_rob_idx = rob_mem_q[rd_ptr_q];
            out_rvfi    = rvfi_mem_q[rd_ptr_q];
        end
    end

endmodule
